// File: rtl/dft_pkg.sv
// Shared types and default sizing for the DFT frame collector.
// Both FSMs import their state encodings from here so the top and any bench agree on them.
package dft_pkg;

   localparam int DEF_LANE_W = 16;
   localparam int DEF_BEATS  = 16;

   typedef enum logic [1:0] {
      C_IDLE = 2'd0,
      C_FILL = 2'd1,
      C_DROP = 2'd2
   } cap_state_t;

   typedef enum logic {
      D_IDLE = 1'b0,
      D_SEND = 1'b1
   } drn_state_t;

endpackage

// File: rtl/dft_frame_bank.sv
// One frame bank: written a whole beat (four lanes) at a time, read back one lane word at a time.
// The storage has no reset; the owner's full flag says whether the contents mean anything.
module dft_frame_bank #(
   parameter int LANE_W = 16,
   parameter int BEATS  = 16
) (
   input  logic                          clk,
   input  logic                          we,
   input  logic [$clog2(BEATS)-1:0]      waddr,
   input  logic [3:0][LANE_W-1:0]        wdata,
   input  logic [$clog2(BEATS)+1:0]      raddr,
   output logic [LANE_W-1:0]             rdata
);

   logic [3:0][LANE_W-1:0] mem [BEATS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Word address: upper bits select the beat, the low two bits select lane Y0..Y3.
   assign rdata = mem[raddr[$clog2(BEATS)+1:2]][raddr[1:0]];

endmodule

// File: rtl/dft_frame_collector.sv
// Collects DFT output frames into ping-pong banks and serializes them onto a valid/ready stream.
// Frames that arrive while both banks are occupied are dropped and flagged as overflow.
module dft_frame_collector
   import dft_pkg::*;
#(
   parameter int LANE_W = DEF_LANE_W,
   parameter int BEATS  = DEF_BEATS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              next_out,
   input  logic [LANE_W-1:0] Y0,
   input  logic [LANE_W-1:0] Y1,
   input  logic [LANE_W-1:0] Y2,
   input  logic [LANE_W-1:0] Y3,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [LANE_W-1:0] m_data,
   output logic              m_last,
   output logic              overflow,
   output logic              proto_err,
   input  logic              err_clr
);

   localparam int BW = $clog2(BEATS);
   localparam int WW = BW + 2;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [WW-1:0] LAST_IDX  = WW'(4 * BEATS - 1);

   cap_state_t        cap_q, cap_d;
   logic [BW-1:0]     cnt_q, cnt_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        full_q, full_d;
   drn_state_t        drn_q, drn_d;
   logic [WW-1:0]     idx_q, idx_d;
   logic              m_valid_q, m_valid_d;
   logic              m_last_q, m_last_d;
   logic [LANE_W-1:0] m_data_q, m_data_d;
   logic              overflow_q, overflow_d;
   logic              proto_err_q, proto_err_d;

   logic                   we_fill;
   logic                   set_full;
   logic                   clr_full;
   logic                   ovf_set;
   logic                   perr_set;
   logic [3:0][LANE_W-1:0] wr_beat;
   logic [WW-1:0]          bank_raddr;
   logic [LANE_W-1:0]      rdata0, rdata1, rd_word;

   assign wr_beat    = {Y3, Y2, Y1, Y0};
   assign bank_raddr = (drn_q == D_SEND) ? idx_q + WW'(1) : '0;
   assign rd_word    = rd_ptr_q ? rdata1 : rdata0;

   dft_frame_bank #(.LANE_W(LANE_W), .BEATS(BEATS)) u_bank0 (
      .clk   (clk),
      .we    (we_fill & ~wr_ptr_q),
      .waddr (cnt_q),
      .wdata (wr_beat),
      .raddr (bank_raddr),
      .rdata (rdata0)
   );

   dft_frame_bank #(.LANE_W(LANE_W), .BEATS(BEATS)) u_bank1 (
      .clk   (clk),
      .we    (we_fill & wr_ptr_q),
      .waddr (cnt_q),
      .wdata (wr_beat),
      .raddr (bank_raddr),
      .rdata (rdata1)
   );

   always_comb begin
      cap_d       = cap_q;
      cnt_d       = cnt_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      drn_d       = drn_q;
      idx_d       = idx_q;
      m_valid_d   = m_valid_q;
      m_last_d    = m_last_q;
      m_data_d    = m_data_q;
      we_fill     = 1'b0;
      set_full    = 1'b0;
      clr_full    = 1'b0;
      ovf_set     = 1'b0;
      perr_set    = 1'b0;

      case (cap_q)
         C_IDLE: begin
            if (next_out) begin
               cnt_d = '0;
               if (full_q[wr_ptr_q]) begin
                  cap_d   = C_DROP;
                  ovf_set = 1'b1;
               end else begin
                  cap_d = C_FILL;
               end
            end
         end
         C_FILL: begin
            we_fill  = 1'b1;
            perr_set = next_out;
            if (cnt_q == LAST_BEAT) begin
               set_full = 1'b1;
               wr_ptr_d = ~wr_ptr_q;
               cap_d    = C_IDLE;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + BW'(1);
            end
         end
         C_DROP: begin
            perr_set = next_out;
            if (cnt_q == LAST_BEAT) begin
               cap_d = C_IDLE;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + BW'(1);
            end
         end
         default: begin
            cap_d = C_IDLE;
            cnt_d = '0;
         end
      endcase

      // A bank completing this very cycle is forwarded so the first word appears one cycle later.
      case (drn_q)
         D_IDLE: begin
            if (full_q[rd_ptr_q] || (set_full && (wr_ptr_q == rd_ptr_q))) begin
               drn_d     = D_SEND;
               idx_d     = '0;
               m_valid_d = 1'b1;
               m_last_d  = 1'b0;
               m_data_d  = rd_word;
            end
         end
         D_SEND: begin
            if (m_ready) begin
               if (idx_q == LAST_IDX) begin
                  clr_full  = 1'b1;
                  rd_ptr_d  = ~rd_ptr_q;
                  drn_d     = D_IDLE;
                  idx_d     = '0;
                  m_valid_d = 1'b0;
                  m_last_d  = 1'b0;
               end else begin
                  idx_d    = idx_q + WW'(1);
                  m_data_d = rd_word;
                  m_last_d = ((idx_q + WW'(1)) == LAST_IDX);
               end
            end
         end
         default: begin
            drn_d     = D_IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
         end
      endcase

      // A freed bank only becomes visible to capture from the next cycle on.
      full_d = full_q;
      if (set_full) begin
         full_d[wr_ptr_q] = 1'b1;
      end
      if (clr_full) begin
         full_d[rd_ptr_q] = 1'b0;
      end

      overflow_d  = (overflow_q & ~err_clr) | ovf_set;
      proto_err_d = (proto_err_q & ~err_clr) | perr_set;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_q       <= C_IDLE;
         cnt_q       <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         full_q      <= '0;
         drn_q       <= D_IDLE;
         idx_q       <= '0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         m_data_q    <= '0;
         overflow_q  <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         cap_q       <= cap_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         full_q      <= full_d;
         drn_q       <= drn_d;
         idx_q       <= idx_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
         m_data_q    <= m_data_d;
         overflow_q  <= overflow_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign m_valid   = m_valid_q;
   assign m_last    = m_last_q;
   assign m_data    = m_data_q;
   assign overflow  = overflow_q;
   assign proto_err = proto_err_q;

endmodule

// File: doc/dft_frame_collector.md
DFT_FRAME_COLLECTOR -- requirements
Module: dft_frame_collector

Interface
REQ-001 SHALL have parameter LANE_W, default 16, width of each DFT output lane.
REQ-002 SHALL have parameter BEATS, default 16, DFT output beats (cycles of Y0..Y3) per frame; legal range 2..64.
REQ-003 SHALL have port clk  input  1  single clock, all state on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports next_out  input  1  DFT frame-start pulse; first beat follows on the next cycle.
REQ-006 SHALL have ports Y0, Y1, Y2, Y3  input  LANE_W each  DFT output lanes, one beat per cycle.
REQ-007 SHALL have port m_valid  output  1  output word valid.
REQ-008 SHALL have port m_ready  input  1  downstream accepts word.
REQ-009 SHALL have port m_data  output  LANE_W  serialized output word.
REQ-010 SHALL have port m_last  output  1  final word of a frame.
REQ-011 SHALL have port overflow  output  1  sticky, a frame was dropped.
REQ-012 SHALL have port proto_err  output  1  sticky, next_out seen during capture or drop.
REQ-013 SHALL have port err_clr  input  1  synchronous clear of overflow and proto_err.

Function
REQ-014 SHALL hold two frame banks (ping-pong), each BEATS x 4 x LANE_W, with per-bank full flag.
REQ-015 Capture FSM SHALL have states C_IDLE, C_FILL, C_DROP.
REQ-016 In C_IDLE, next_out=1 with write bank empty -> C_FILL; with write bank full -> C_DROP and overflow set.
REQ-017 Beats SHALL be captured on the BEATS cycles following the next_out cycle, beat counter 0..BEATS-1, no gaps.
REQ-018 On beat BEATS-1 in C_FILL: write bank full flag set, write pointer toggles, FSM -> C_IDLE.
REQ-019 C_DROP SHALL count BEATS cycles discarding data, then -> C_IDLE; write pointer unchanged.
REQ-020 next_out during C_FILL or C_DROP SHALL be ignored and set proto_err; capture continues.
REQ-021 Drain FSM SHALL have states D_IDLE, D_SEND; D_IDLE -> D_SEND when read bank full.
REQ-022 In D_SEND, m_valid=1; word order beat 0..BEATS-1, within beat Y0,Y1,Y2,Y3; index advances only on m_valid&m_ready.
REQ-023 m_last SHALL be 1 exactly on word 4*BEATS-1; its handshake clears the read bank full flag, toggles read pointer, -> D_IDLE.
REQ-024 m_valid SHALL first rise the cycle after the capturing beat BEATS-1 (latency 1); m_data/m_last stable while m_valid&!m_ready.
REQ-025 A bank freed in cycle t SHALL be usable by next_out sampled in cycle t+1 or later, not t.
REQ-026 err_clr together with a new error event in the same cycle: the set SHALL win.

Reset
REQ-027 rst SHALL asynchronously force C_IDLE, D_IDLE, both banks empty, pointers and counters 0, m_valid=0, m_last=0, m_data=0, overflow=0, proto_err=0.
REQ-028 rst mid-capture or mid-drain SHALL discard the partial frame; bank contents need no reset.

Structure
REQ-029 Shared package dft_pkg SHALL hold capture/drain state enums and default LANE_W/BEATS constants.
REQ-030 One sub-module dft_frame_bank SHALL implement a single bank (write beat, read word); instantiated twice.

Verification (BEATS=4)
REQ-031 next_out, beats Y0..Y3={1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, m_ready=1 -> m_data 1..16 consecutive, m_last on 16, m_valid rises one cycle after last beat.
REQ-032 Same frame, m_ready toggling 1/0 -> 16 words in order, no duplicate/loss, data held while stalled.
REQ-033 m_ready=0, three back-to-back frames -> frames 1,2 stored, frame 3 dropped, overflow=1; release -> 32 words, frames 1 then 2.
REQ-034 next_out reasserted on beat 2 of a capture -> proto_err=1, frame completes normally; err_clr -> proto_err=0.
REQ-035 rst asserted on beat 2 of capture, then clean frame -> only clean frame output, flags 0.
REQ-036 Both banks full, last word of bank 0 accepted in cycle t with next_out in t -> dropped (overflow=1); next_out at t+1 -> captured.
